// File: rtl/decode_ctrl.sv
// decode_ctrl: RV32I decode/control stage feeding the ID/EX register.
// Decodes the fetched opcode into immediate-select and datapath controls,
// detects load-use hazards, and honours flush and execute-stage stall.
module decode_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        stall_req,
    output logic        ex_valid,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_pc,
    output logic [3:0]  ex_imm_sel,
    output logic        ex_rf_we,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_br,
    output logic        ex_jump,
    output logic        ex_illegal,
    output logic [1:0]  ex_wb_sel,
    output logic        ex_a_sel,
    output logic        ex_b_sel
);

    localparam logic [3:0] IMM_R  = 4'd0;
    localparam logic [3:0] IMM_S  = 4'd1;
    localparam logic [3:0] IMM_B  = 4'd2;
    localparam logic [3:0] IMM_U  = 4'd3;
    localparam logic [3:0] IMM_J  = 4'd4;
    localparam logic [3:0] IMM_I  = 4'd5;
    localparam logic [3:0] IMM_IS = 4'd6;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic [3:0] imm_sel;
        logic       rf_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       br;
        logic       jump;
        logic       illegal;
        logic [1:0] wb_sel;
        logic       a_sel;
        logic       b_sel;
    } ctrl_t;

    // Bubble controls: everything off, immediate select parked on I-type.
    localparam ctrl_t CTRL_BUBBLE = '{imm_sel: IMM_I, wb_sel: WB_ALU, default: 1'b0};

    ctrl_t       dec_ctrl;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;

    ctrl_t       ctrl_d,     ctrl_q;
    logic        ex_valid_d, ex_valid_q;
    logic [31:0] ex_inst_d,  ex_inst_q;
    logic [31:0] ex_pc_d,    ex_pc_q;

    // Opcode decode of the fetched instruction into controls and register usage.
    always_comb begin
        dec_ctrl = CTRL_BUBBLE;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (if_inst[6:0])
            7'b0110111, 7'b0010111: begin // LUI, AUIPC (EX zeroes operand A for LUI)
                dec_ctrl.imm_sel = IMM_U;
                dec_ctrl.rf_we   = 1'b1;
                dec_ctrl.a_sel   = 1'b1;
                dec_ctrl.b_sel   = 1'b1;
                uses_rs1         = 1'b0;
            end
            7'b1101111: begin // JAL
                dec_ctrl.imm_sel = IMM_J;
                dec_ctrl.rf_we   = 1'b1;
                dec_ctrl.jump    = 1'b1;
                dec_ctrl.a_sel   = 1'b1;
                dec_ctrl.b_sel   = 1'b1;
                dec_ctrl.wb_sel  = WB_PC4;
                uses_rs1         = 1'b0;
            end
            7'b1100111: begin // JALR
                dec_ctrl.rf_we   = 1'b1;
                dec_ctrl.jump    = 1'b1;
                dec_ctrl.b_sel   = 1'b1;
                dec_ctrl.wb_sel  = WB_PC4;
            end
            7'b1100011: begin // BRANCH
                dec_ctrl.imm_sel = IMM_B;
                dec_ctrl.br      = 1'b1;
                dec_ctrl.a_sel   = 1'b1;
                dec_ctrl.b_sel   = 1'b1;
                uses_rs2         = 1'b1;
            end
            7'b0000011: begin // LOAD
                dec_ctrl.rf_we   = 1'b1;
                dec_ctrl.mem_rd  = 1'b1;
                dec_ctrl.b_sel   = 1'b1;
                dec_ctrl.wb_sel  = WB_MEM;
            end
            7'b0100011: begin // STORE
                dec_ctrl.imm_sel = IMM_S;
                dec_ctrl.mem_wr  = 1'b1;
                dec_ctrl.b_sel   = 1'b1;
                uses_rs2         = 1'b1;
            end
            7'b0010011: begin // OP-IMM; shifts use the shamt immediate form
                dec_ctrl.imm_sel = (if_inst[13:12] == 2'b01) ? IMM_IS : IMM_I;
                dec_ctrl.rf_we   = 1'b1;
                dec_ctrl.b_sel   = 1'b1;
            end
            7'b0110011: begin // OP
                dec_ctrl.imm_sel = IMM_R;
                dec_ctrl.rf_we   = 1'b1;
                uses_rs2         = 1'b1;
            end
            7'b1110011: begin // SYSTEM
                dec_ctrl.rf_we   = 1'b1;
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
                uses_rs1         = 1'b0;
            end
        endcase
    end

    assign hazard = ex_valid_q && ex_ctrl_mem_rd() && (ex_inst_q[11:7] != 5'd0) && if_valid &&
                    ((uses_rs1 && (if_inst[19:15] == ex_inst_q[11:7])) ||
                     (uses_rs2 && (if_inst[24:20] == ex_inst_q[11:7])));

    function automatic logic ex_ctrl_mem_rd();
        return ctrl_q.mem_rd;
    endfunction

    assign stall_req = hazard && !flush;

    // ID/EX next-state selection: flush > ex_stall > hazard > idle > load.
    always_comb begin
        ctrl_d     = ctrl_q;
        ex_valid_d = ex_valid_q;
        ex_inst_d  = ex_inst_q;
        ex_pc_d    = ex_pc_q;
        if (flush || (!ex_stall && (hazard || !if_valid))) begin
            ctrl_d     = CTRL_BUBBLE;
            ex_valid_d = 1'b0;
            ex_inst_d  = NOP_INST;
        end else if (!ex_stall) begin
            ctrl_d     = dec_ctrl;
            ex_valid_d = 1'b1;
            ex_inst_d  = if_inst;
            ex_pc_d    = if_pc;
        end
    end

    // ID/EX register; reset loads a bubble with a cleared PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= CTRL_BUBBLE;
            ex_valid_q <= 1'b0;
            ex_inst_q  <= NOP_INST;
            ex_pc_q    <= 32'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            ex_valid_q <= ex_valid_d;
            ex_inst_q  <= ex_inst_d;
            ex_pc_q    <= ex_pc_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_inst    = ex_inst_q;
    assign ex_pc      = ex_pc_q;
    assign ex_imm_sel = ctrl_q.imm_sel;
    assign ex_rf_we   = ctrl_q.rf_we;
    assign ex_mem_rd  = ctrl_q.mem_rd;
    assign ex_mem_wr  = ctrl_q.mem_wr;
    assign ex_br      = ctrl_q.br;
    assign ex_jump    = ctrl_q.jump;
    assign ex_illegal = ctrl_q.illegal;
    assign ex_wb_sel  = ctrl_q.wb_sel;
    assign ex_a_sel   = ctrl_q.a_sel;
    assign ex_b_sel   = ctrl_q.b_sel;

endmodule
